// File: rtl/pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: host register map,
// CONTROL/STATUS bit positions and the sequencer FSM state encoding.
package pio_seq_pkg;

  // Host slave register addresses
  localparam logic [2:0] ADDR_CONTROL = 3'd0;
  localparam logic [2:0] ADDR_PERIOD  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  // Addresses 4..7 select PATTERN[0..3]; bit 2 of the address marks the bank
  localparam int ADDR_PATTERN_SEL_BIT = 2;

  // CONTROL register bits
  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_ONESHOT_BIT = 1;

  // STATUS register bits (STEP occupies bits 1:0)
  localparam int STATUS_BUSY_BIT = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pio_seq_timer.sv
// Inter-step delay counter: synchronous clear, load and decrement with a
// zero flag. Clear has priority over load, load over decrement.
module pio_seq_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Counter register; saturates at zero so a stray decrement cannot wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pio_pattern_sequencer.sv
// PIO pattern sequencer: a host-programmable table of four 4-bit patterns
// is written one entry at a time to an output PIO slave, with a programmable
// delay between writes, in free-running or one-shot mode.
module pio_pattern_sequencer
  import pio_seq_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int NUM_STEPS    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  logic                    ctrl_enable;
  logic                    ctrl_oneshot;
  logic [PERIOD_WIDTH-1:0] period;
  logic [3:0]              pattern [NUM_STEPS];

  seq_state_t        state, state_next;
  logic [STEP_W-1:0] step, step_next;

  logic host_wr;
  logic ctrl_wr;
  logic en_eff;
  logic ctrl_selfclr;
  logic tmr_clear;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;
  logic unused_writedata;

  assign host_wr = chipselect && !write_n;
  assign ctrl_wr = host_wr && (address == ADDR_CONTROL);

  // A host write to CONTROL landing this cycle is honoured immediately by a
  // running sequence, so a disable can never be overtaken by a new PIO write.
  assign en_eff = ctrl_wr ? writedata[CTRL_ENABLE_BIT] : ctrl_enable;

  // Upper write-data bits have no register behind them
  assign unused_writedata = &{1'b0, writedata[31:PERIOD_WIDTH]};

  // CONTROL register; the one-shot completion clears the whole register,
  // but a host write in the same cycle takes precedence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable  <= 1'b0;
      ctrl_oneshot <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_enable  <= writedata[CTRL_ENABLE_BIT];
      ctrl_oneshot <= writedata[CTRL_ONESHOT_BIT];
    end else if (ctrl_selfclr) begin
      ctrl_enable  <= 1'b0;
      ctrl_oneshot <= 1'b0;
    end
  end

  // PERIOD register; only sampled by the timer at its next load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
    end else if (host_wr && (address == ADDR_PERIOD)) begin
      period <= writedata[PERIOD_WIDTH-1:0];
    end
  end

  // Pattern table; an entry is only read out during its WRITE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        pattern[i] <= 4'd0;
      end
    end else if (host_wr && address[ADDR_PATTERN_SEL_BIT]) begin
      pattern[address[STEP_W-1:0]] <= writedata[3:0];
    end
  end

  // FSM state and step index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  // Next-state logic and timer control
  always_comb begin
    state_next   = state;
    step_next    = step;
    tmr_clear    = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    ctrl_selfclr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_enable) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The write in progress always completes; only the successor changes
        if (!en_eff) begin
          state_next = ST_IDLE;
        end else if (ctrl_oneshot && (step == LAST_STEP)) begin
          state_next   = ST_IDLE;
          ctrl_selfclr = 1'b1;
        end else begin
          state_next = ST_WAIT;
          tmr_load   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!en_eff) begin
          state_next = ST_IDLE;
        end else if (tmr_zero) begin
          state_next = ST_WRITE;
          step_next  = step + 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (state_next == ST_IDLE) begin
      step_next = '0;
      tmr_clear = 1'b1;
    end
  end

  pio_seq_timer #(
    .WIDTH (PERIOD_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (tmr_clear),
    .load       (tmr_load),
    .load_value (period),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  // Master strobes decode straight from the state register so reset drops
  // them in the same instant
  assign m_address    = 2'd0;
  assign m_chipselect = (state == ST_WRITE);
  assign m_write_n    = (state != ST_WRITE);
  assign m_writedata  = (state == ST_WRITE) ? {28'd0, pattern[step]} : 32'd0;

  // Host read mux, zero-extended, no wait states
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CONTROL: begin
        readdata[CTRL_ENABLE_BIT]  = ctrl_enable;
        readdata[CTRL_ONESHOT_BIT] = ctrl_oneshot;
      end
      ADDR_PERIOD: begin
        readdata[PERIOD_WIDTH-1:0] = period;
      end
      ADDR_STATUS: begin
        readdata[STEP_W-1:0]     = step;
        readdata[STATUS_BUSY_BIT] = (state != ST_IDLE);
      end
      default: begin
        if (address[ADDR_PATTERN_SEL_BIT]) begin
          readdata[3:0] = pattern[address[STEP_W-1:0]];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Scoreboard bench for pio_pattern_sequencer: directed host programs push
// expected PIO writes (data and spacing in cycles); a monitor pops and
// compares every PIO write the DUT performs.
module tb_pio_pattern_sequencer;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  typedef struct {
    logic [3:0] data;
    int         gap;   // cycles since previous PIO write, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_cyc = 0;

  pio_pattern_sequencer #(
    .PERIOD_WIDTH (24),
    .NUM_STEPS    (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every PIO write must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && m_chipselect && !m_write_n) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pio_write: got data 0x%0h at cycle %0d expected none", m_writedata, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pio_data", m_writedata, {28'd0, e.data});
          chk("pio_addr", {30'd0, m_address}, 32'd0);
          if (e.gap != 0) chk("pio_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic push(input logic [3:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_reg(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic wait_empty(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expected writes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Returns at the falling edge inside the WRITE cycle carrying data d
  task automatic wait_write(input logic [3:0] d, input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (m_chipselect && !m_write_n && (m_writedata[3:0] == d)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: no PIO write of 0x%0h seen, required one", name, d);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    chk("rst_m_write_n", {31'd0, m_write_n}, 32'd1);
    chk("rst_m_chipselect", {31'd0, m_chipselect}, 32'd0);
    for (int a = 0; a < 8; a++) check_reg(3'(a), 32'd0, $sformatf("rst_readdata_%0d", a));

    // Free-running: PERIOD=3 -> writes 5 cycles apart
    host_write(3'd4, 32'h1);
    host_write(3'd5, 32'h2);
    host_write(3'd6, 32'h4);
    host_write(3'd7, 32'h8);
    host_write(3'd1, 32'd3);
    check_reg(3'd1, 32'd3, "period_rb");
    check_reg(3'd6, 32'h4, "pattern2_rb");
    push(4'h1, 0); push(4'h2, 5); push(4'h4, 5); push(4'h8, 5); push(4'h1, 5);
    host_write(3'd0, 32'h1);
    check_reg(3'd2, 32'h4, "status_busy_step0");
    wait_empty(100, "freerun_writes");
    host_write(3'd0, 32'h0);
    repeat (20) @(negedge clk);
    check_reg(3'd2, 32'h0, "freerun_stop_status");

    // One-shot with PERIOD=0 -> four writes 2 cycles apart
    host_write(3'd1, 32'd0);
    push(4'h1, 0); push(4'h2, 2); push(4'h4, 2); push(4'h8, 2);
    host_write(3'd0, 32'h3);
    wait_empty(60, "oneshot_writes");
    repeat (10) @(negedge clk);
    check_reg(3'd0, 32'h0, "oneshot_control");
    check_reg(3'd2, 32'h0, "oneshot_status");

    // Disable during the WRITE cycle of step 2
    host_write(3'd1, 32'd3);
    push(4'h1, 0); push(4'h2, 5); push(4'h4, 5);
    host_write(3'd0, 32'h1);
    wait_write(4'h4, 100, "disable_in_write_find");
    address    = 3'd0;
    writedata  = 32'h0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (20) @(negedge clk);
    check_reg(3'd2, 32'h0, "disable_in_write_status");
    chk("disable_in_write_sb", sb.size(), 32'd0);

    // Pattern update in WAIT and ignored STATUS write
    push(4'h1, 0); push(4'hF, 5); push(4'h4, 5);
    host_write(3'd0, 32'h1);
    wait_write(4'h1, 100, "pattern_update_find");
    host_write(3'd5, 32'hF);
    host_write(3'd2, 32'h3);
    check_reg(3'd2, 32'h5, "status_write_ignored");
    wait_empty(100, "pattern_update_writes");
    host_write(3'd0, 32'h0);
    repeat (10) @(negedge clk);
    check_reg(3'd5, 32'hF, "pattern1_rb");
    check_reg(3'd2, 32'h0, "pattern_update_stop_status");

    // Reset pulse in the middle of a long WAIT
    host_write(3'd1, 32'd100);
    push(4'h1, 0);
    host_write(3'd0, 32'h1);
    wait_empty(50, "reset_mid_wait_first");
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstpulse_m_write_n", {31'd0, m_write_n}, 32'd1);
    chk("rstpulse_m_chipselect", {31'd0, m_chipselect}, 32'd0);
    chk("rstpulse_m_writedata", m_writedata, 32'd0);
    chk("rstpulse_m_address", {30'd0, m_address}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("rstpulse_readdata_%0d", a), readdata, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (150) @(negedge clk);
    check_reg(3'd0, 32'h0, "post_reset_control");
    check_reg(3'd1, 32'h0, "post_reset_period");
    check_reg(3'd2, 32'h0, "post_reset_status");

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
